bp_cac_edge_buffer: RTL and testbench

BP_CAC_EDGE_BUFFER -- requirements
Module: bp_cac_edge_buffer

---
 rtl/bp_cac_edge_buffer.sv | 178 +++++++++++++++++
 tb/tb_bp_cac_edge_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cac_edge_buffer.sv
// Edge buffer for the coherence NoC: a small circular flit FIFO with a
// packet tracker on the input side and a quiesce FSM that stops new packets
// from entering while letting any in-flight packet finish.
module bp_cac_edge_buffer #(
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned cord_width_p = 7,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned els_p        = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    in_v_i,
    input  logic [flit_width_p-1:0] in_data_i,
    output logic                    in_ready_and_o,

    output logic                    out_v_o,
    output logic [flit_width_p-1:0] out_data_o,
    input  logic                    out_ready_and_i,

    input  logic                    quiesce_i,
    output logic                    quiesced_o,
    output logic [15:0]             pkt_count_o
);

    localparam int unsigned PtrW = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned CntW = $clog2(els_p + 1);

    typedef enum logic {
        TrkHdr,
        TrkBody
    } trk_state_e;

    typedef enum logic [1:0] {
        QsRun,
        QsDrain,
        QsQuiesced
    } qs_state_e;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [flit_width_p-1:0] mem_q [els_p];
    logic [PtrW-1:0]         wptr_q, wptr_d;
    logic [PtrW-1:0]         rptr_q, rptr_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic full, empty, enq, deq;

    // Tracker and quiesce state
    trk_state_e             trk_q, trk_d;
    logic [len_width_p-1:0] rem_q, rem_d;
    qs_state_e              qs_q, qs_d;
    logic [15:0]            pkt_q, pkt_d;

    logic                   hdr_block;
    logic [len_width_p-1:0] hdr_len;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        ptr_inc = (p == PtrW'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CntW'(els_p));
    assign empty   = (cnt_q == '0);
    assign hdr_len = in_data_i[cord_width_p +: len_width_p];

    // Header admission is gated by registered FSM state, so a header arriving
    // in the same cycle quiesce_i rises is still taken.
    assign hdr_block = (qs_q != QsRun) && (trk_q == TrkHdr);

    // reset_n_i is folded in so ready is low throughout reset, even before
    // any clock edge.
    assign in_ready_and_o = reset_n_i & ~full & ~hdr_block;
    assign out_v_o        = ~empty;
    assign out_data_o     = mem_q[rptr_q];
    assign quiesced_o     = (qs_q == QsQuiesced);
    assign pkt_count_o    = pkt_q;

    assign enq = in_v_i & in_ready_and_o;
    assign deq = out_v_o & out_ready_and_i;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (enq) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (deq) begin
            rptr_d = ptr_inc(rptr_q);
        end
        unique case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Flit storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q] <= in_data_i;
        end
    end

    // Packet tracker next-state and header counting
    always_comb begin
        trk_d = trk_q;
        rem_d = rem_q;
        pkt_d = pkt_q;
        if (enq) begin
            unique case (trk_q)
                TrkHdr: begin
                    pkt_d = pkt_q + 16'd1;
                    if (hdr_len != '0) begin
                        trk_d = TrkBody;
                        rem_d = hdr_len;
                    end
                end
                TrkBody: begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == len_width_p'(1)) begin
                        trk_d = TrkHdr;
                    end
                end
                default: trk_d = TrkHdr;
            endcase
        end
    end

    // Quiesce FSM next-state; dropping quiesce_i always returns to RUN
    always_comb begin
        qs_d = qs_q;
        unique case (qs_q)
            QsRun: begin
                if (quiesce_i) begin
                    qs_d = QsDrain;
                end
            end
            QsDrain: begin
                if (!quiesce_i) begin
                    qs_d = QsRun;
                end else if ((trk_q == TrkHdr) && empty) begin
                    qs_d = QsQuiesced;
                end
            end
            QsQuiesced: begin
                if (!quiesce_i) begin
                    qs_d = QsRun;
                end
            end
            default: qs_d = QsRun;
        endcase
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            trk_q  <= TrkHdr;
            rem_q  <= '0;
            qs_q   <= QsRun;
            pkt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            trk_q  <= trk_d;
            rem_q  <= rem_d;
            qs_q   <= qs_d;
            pkt_q  <= pkt_d;
        end
    end

endmodule

// File: tb/tb_bp_cac_edge_buffer.sv
// Self-checking bench for bp_cac_edge_buffer. Accepted flits go into a
// scoreboard queue; the monitor pops and compares when the DUT dequeues.
module tb_bp_cac_edge_buffer;

    localparam int unsigned W   = 64;
    localparam int unsigned CW  = 7;
    localparam int unsigned LW  = 4;
    localparam int unsigned ELS = 2;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b1;
    logic          in_v_i = 1'b0;
    logic [W-1:0]  in_data_i = '0;
    logic          in_ready_and_o;
    logic          out_v_o;
    logic [W-1:0]  out_data_o;
    logic          out_ready_and_i = 1'b0;
    logic          quiesce_i = 1'b0;
    logic          quiesced_o;
    logic [15:0]   pkt_count_o;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } sb_t;

    sb_t sb_q[$];
    int  cyc = 0;
    bit  chk_lat = 1'b0;
    int  n_checks = 0;
    int  n_pass = 0;

    bp_cac_edge_buffer #(
        .flit_width_p(W),
        .cord_width_p(CW),
        .len_width_p (LW),
        .els_p       (ELS)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .in_v_i         (in_v_i),
        .in_data_i      (in_data_i),
        .in_ready_and_o (in_ready_and_o),
        .out_v_o        (out_v_o),
        .out_data_o     (out_data_o),
        .out_ready_and_i(out_ready_and_i),
        .quiesce_i      (quiesce_i),
        .quiesced_o     (quiesced_o),
        .pkt_count_o    (pkt_count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: pop before push so a bypassing DUT cannot match a same-cycle flit
    always @(negedge clk_i) begin
        sb_t e;
        if (reset_n_i) begin
            if (out_v_o && out_ready_and_i) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got flit %h, expected none", out_data_o);
                end else begin
                    e = sb_q.pop_front();
                    if (out_data_o !== e.data || (chk_lat && cyc != e.cyc + 1)) begin
                        $display("FAIL sb_data: got %h at cycle %0d, expected %h at cycle %0d",
                                 out_data_o, cyc, e.data, e.cyc + 1);
                    end else begin
                        n_pass++;
                    end
                end
            end
            if (in_v_i && in_ready_and_o) begin
                sb_q.push_back('{data: in_data_i, cyc: cyc});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] mk(input int unsigned len, input int unsigned tag);
        mk = (64'(tag) << 11) | (64'(len & 32'hF) << 7) | 64'h5;
    endfunction

    function automatic logic [W-1:0] body();
        body = {$urandom, $urandom};
    endfunction

    // Offer one flit for one cycle and check the ready seen
    task automatic offer(input logic [W-1:0] d, input logic exp_rdy, input string nm);
        in_v_i    = 1'b1;
        in_data_i = d;
        @(negedge clk_i);
        n_checks++;
        if (in_ready_and_o !== exp_rdy) begin
            $display("FAIL %s: in_ready_and_o=%b, expected %b", nm, in_ready_and_o, exp_rdy);
        end else begin
            n_pass++;
        end
        @(posedge clk_i);
        #1;
        in_v_i = 1'b0;
    endtask

    task automatic check_pkt(input logic [15:0] exp, input string nm);
        n_checks++;
        if (pkt_count_o !== exp) begin
            $display("FAIL %s: pkt_count_o=%h, expected %h", nm, pkt_count_o, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drain(input string nm);
        int k = 0;
        out_ready_and_i = 1'b1;
        @(negedge clk_i);
        while (out_v_o === 1'b1 && k < 20) begin
            @(negedge clk_i);
            k++;
        end
        n_checks++;
        if (out_v_o !== 1'b0 || sb_q.size() != 0) begin
            $display("FAIL %s: out_v_o=%b pending=%0d, expected 0 and 0", nm, out_v_o, sb_q.size());
        end else begin
            n_pass++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #1;
        reset_n_i = 1'b0;
        #2;
        n_checks++;
        if ({out_v_o, in_ready_and_o, quiesced_o} !== 3'b000 || pkt_count_o !== 16'h0) begin
            $display("FAIL reset_state: v/rdy/q=%b%b%b pkt=%h, expected 000 and 0000",
                     out_v_o, in_ready_and_o, quiesced_o, pkt_count_o);
        end else begin
            n_pass++;
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        n_checks++;
        if (in_ready_and_o !== 1'b1) begin
            $display("FAIL reset_release_ready: in_ready_and_o=%b, expected 1", in_ready_and_o);
        end else begin
            n_pass++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_stream();
        out_ready_and_i = 1'b1;
        chk_lat = 1'b1;
        offer(mk(0, 1), 1'b1, "stream_h0");
        offer(mk(2, 2), 1'b1, "stream_h2");
        offer(body(), 1'b1, "stream_b2a");
        offer(body(), 1'b1, "stream_b2b");
        offer(mk(1, 3), 1'b1, "stream_h1");
        offer(body(), 1'b1, "stream_b1");
        drain("stream_drain");
        chk_lat = 1'b0;
        check_pkt(16'd3, "stream_pkt");
    endtask

    task automatic test_backpressure();
        out_ready_and_i = 1'b0;
        offer(mk(0, 10), 1'b1, "bp_first");
        offer(mk(0, 11), 1'b1, "bp_second");
        offer(mk(0, 12), 1'b0, "bp_full");
        // Dequeue in the same cycle must not open the input
        out_ready_and_i = 1'b1;
        offer(mk(0, 12), 1'b0, "bp_full_deq");
        out_ready_and_i = 1'b0;
        offer(mk(0, 12), 1'b1, "bp_third");
        drain("bp_drain");
        check_pkt(16'd6, "bp_pkt");
    endtask

    task automatic test_quiesce();
        int k = 0;
        out_ready_and_i = 1'b1;
        offer(mk(3, 20), 1'b1, "q_hdr");
        quiesce_i = 1'b1;
        offer(body(), 1'b1, "q_body1");
        n_checks++;
        if (quiesced_o !== 1'b0) begin
            $display("FAIL q_mid_packet: quiesced_o=%b, expected 0", quiesced_o);
        end else begin
            n_pass++;
        end
        offer(body(), 1'b1, "q_body2");
        offer(body(), 1'b1, "q_body3");
        offer(mk(0, 21), 1'b0, "q_hdr_refused");
        while (quiesced_o !== 1'b1 && k < 10) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        n_checks++;
        if (quiesced_o !== 1'b1 || out_v_o !== 1'b0 || in_ready_and_o !== 1'b0) begin
            $display("FAIL q_reached: q/v/rdy=%b%b%b, expected 100",
                     quiesced_o, out_v_o, in_ready_and_o);
        end else begin
            n_pass++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL q_sb_empty: pending=%0d, expected 0", sb_q.size());
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_release();
        quiesce_i = 1'b0;
        offer(mk(0, 30), 1'b0, "rel_blocked");
        offer(mk(0, 30), 1'b1, "rel_accept");
        n_checks++;
        if (quiesced_o !== 1'b0) begin
            $display("FAIL rel_state: quiesced_o=%b, expected 0", quiesced_o);
        end else begin
            n_pass++;
        end
        check_pkt(16'd8, "rel_pkt");
        drain("rel_drain");
    endtask

    task automatic test_async_reset();
        out_ready_and_i = 1'b0;
        offer(mk(2, 40), 1'b1, "ar_hdr");
        #2;
        reset_n_i = 1'b0;
        #1;
        n_checks++;
        if (out_v_o !== 1'b0 || in_ready_and_o !== 1'b0 || pkt_count_o !== 16'h0) begin
            $display("FAIL ar_immediate: v=%b rdy=%b pkt=%h, expected 0 0 0000",
                     out_v_o, in_ready_and_o, pkt_count_o);
        end else begin
            n_pass++;
        end
        sb_q.delete();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_and_i = 1'b1;
        offer(mk(0, 41), 1'b1, "ar_new_hdr");
        check_pkt(16'd1, "ar_pkt");
        drain("ar_drain");
    endtask

    task automatic test_wrap();
        reset_n_i = 1'b0;
        #1;
        sb_q.delete();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_and_i = 1'b1;
        in_v_i = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data_i = mk(0, i);
            @(posedge clk_i);
            #1;
        end
        in_v_i = 1'b0;
        check_pkt(16'hFFFF, "wrap_preload");
        offer(mk(0, 50), 1'b1, "wrap_hdr");
        check_pkt(16'h0000, "wrap_rollover");
        offer(mk(15, 51), 1'b1, "long_hdr");
        for (int i = 0; i < 15; i++) begin
            offer(body(), 1'b1, "long_body");
        end
        check_pkt(16'h0001, "long_body_not_hdr");
        offer(mk(0, 52), 1'b1, "long_next_hdr");
        check_pkt(16'h0002, "long_next_counted");
        drain("wrap_drain");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_quiesce();
        test_release();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
